regfile_bank: RTL and testbench
===============================

REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 32, number of registers; SHALL be at least 2.
REQ-003 Parameter ZERO_REG, default 1, 1 = register 0 reads zero and ignores writes.
REQ-004 Parameter BYPASS, default 1, 1 = same-cycle write data is forwarded to the read ports.
REQ-005 Local parameter AW = ceil(log2(DEPTH)), address width.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 res  in  1  reset; synchronous and active-high.
REQ-008 we  in  1  write request.
REQ-009 waddr  in  AW  write address.
REQ-010 d  in  WIDTH  write data.
REQ-011 be  in  WIDTH/8  byte enables; bit i gates d[8i+7:8i].
REQ-012 raddr_a, raddr_b  in  AW each  read addresses.
REQ-013 q_a, q_b  out  WIDTH each  read data, combinational from storage, addresses and bypass path.
REQ-014 clr_start  in  1  starts a sequential clear sweep.
REQ-015 busy  out  1  high while the clear sweep runs.
REQ-016 wr_drop  out  1  registered one-cycle pulse; a write was rejected.
REQ-017 dirty  out  DEPTH  per-register flag; bit n set = register n written since its last clear.

Function
REQ-018 Accepted write: we=1, FSM in IDLE, waddr<DEPTH, and not (ZERO_REG=1 and waddr=0); only the bytes with be=1 update at the clock edge.
REQ-019 An accepted write with be=0 still sets dirty[waddr].
REQ-020 Reads: q_x = stored register raddr_x; zero if raddr_x>=DEPTH, or if ZERO_REG=1 and raddr_x=0.
REQ-021 BYPASS=1 with an accepted write in the same cycle and raddr_x=waddr: q_x = stored value with the enabled bytes replaced by d. BYPASS=0: q_x shows the old value until the next cycle.
REQ-022 FSM states: IDLE, CLEAR. IDLE->CLEAR when clr_start=1; CLEAR->IDLE in the cycle in which ptr=DEPTH-1 is cleared.
REQ-023 Entry to CLEAR sets ptr=0. Each CLEAR cycle zeroes register ptr and dirty[ptr], then increments ptr. A full sweep takes exactly DEPTH cycles.
REQ-024 busy = (state==CLEAR), including the final sweep cycle; busy is low in the cycle after that.
REQ-025 clr_start while in CLEAR is ignored; the sweep does not restart.
REQ-026 we=1 while busy: write discarded, dirty unchanged, no bypass, wr_drop=1 next cycle.
REQ-027 we=1 with waddr>=DEPTH, or with ZERO_REG=1 and waddr=0: write discarded, wr_drop=1 next cycle.
REQ-028 clr_start and we together in IDLE: the write is accepted in that cycle; the sweep starts next cycle and later clears it.
REQ-029 Reads during CLEAR return current storage; already-swept registers read zero.

Reset
REQ-030 res=1 at a clock edge: all registers zero, dirty=0, state=IDLE, ptr=0, busy=0, wr_drop=0.
REQ-031 res takes priority over writes, clr_start and an in-progress sweep; a sweep interrupted by reset does not resume.
REQ-032 After reset release, q_a and q_b read zero for every address until a write occurs.

Verification
REQ-033 Reset; write 0xDEADBEEF to reg 5 with be=0xF; raddr_a=5 next cycle -> q_a=0xDEADBEEF, dirty=0x00000020.
REQ-034 Reg 5 = 0xDEADBEEF; write d=0x11223344, be=0x2, raddr_b=5 same cycle -> q_b=0xDEAD33EF combinationally (BYPASS=1), stored 0xDEAD33EF.
REQ-035 ZERO_REG=1; write 0xFFFFFFFF to reg 0 -> q_a=0 at raddr_a=0, dirty[0]=0, wr_drop=1 next cycle.
REQ-036 Regs 3 and 31 written; pulse clr_start -> busy high exactly 32 cycles; afterwards all reads zero, dirty=0.
REQ-037 During a sweep, we=1 to reg 7 -> wr_drop=1 next cycle, reg 7 remains 0 after the sweep; a second clr_start mid-sweep does not extend busy.
REQ-038 Assert res at sweep cycle 10 -> next cycle busy=0, dirty=0, all registers zero, state IDLE.

Source files
------------

// File: rtl/regfile_bank.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bank
// Purpose  : Dual-read, single-write register bank with byte enables,
//            optional hard-wired zero register, optional write-to-read
//            bypass, per-register dirty flags and a sequential clear sweep.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1        clock, all state updates on the rising edge
//   res        in   1        synchronous active-high reset
//   we         in   1        write request
//   waddr      in   AW       write address
//   d          in   WIDTH    write data
//   be         in   WIDTH/8  byte enables, bit i gates d[8i+7:8i]
//   raddr_a/b  in   AW       read addresses
//   q_a/q_b    out  WIDTH    combinational read data
//   clr_start  in   1        start a clear sweep (ignored while sweeping)
//   busy       out  1        clear sweep in progress
//   wr_drop    out  1        registered pulse, previous-cycle write rejected
//   dirty      out  DEPTH    per-register written-since-clear flags
// ============================================================================
module regfile_bank #(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               res,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   d,
    input  logic [WIDTH/8-1:0] be,
    input  logic [AW-1:0]      raddr_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   q_a,
    output logic [WIDTH-1:0]   q_b,
    input  logic               clr_start,
    output logic               busy,
    output logic               wr_drop,
    output logic [DEPTH-1:0]   dirty
);

    localparam int            NB      = WIDTH / 8;
    // Address compares are done one bit wider so non-power-of-two depths
    // can flag out-of-range addresses.
    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] dirty_q;
    logic             wr_drop_q, wr_drop_d;

    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wold;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] stored_a, stored_b;
    logic             waddr_ok, wzero_hit, wr_acc;
    logic             ra_ok, rb_ok;

    // Expand byte enables into a bit mask.
    for (genvar g = 0; g < NB; g++) begin : g_mask
        assign wmask[8*g +: 8] = {8{be[g]}};
    end

    // ------------------------------------------------------------------
    // Write acceptance
    // ------------------------------------------------------------------
    always_comb begin
        waddr_ok  = ({1'b0, waddr} < c_DEPTH);
        wzero_hit = (ZERO_REG != 0) && (waddr == '0);
        wr_acc    = we && (state_q == S_IDLE) && waddr_ok && !wzero_hit;
        wr_drop_d = we && !wr_acc;
    end

    // Storage lookups written as decoders so out-of-range addresses of a
    // non-power-of-two bank never index past the array.
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        wold     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) stored_a = mem_q[i];
            if (raddr_b == AW'(i)) stored_b = mem_q[i];
            if (waddr   == AW'(i)) wold     = mem_q[i];
        end
    end

    // Stored value with the enabled bytes replaced; used for both the
    // write-back and the bypass path so they can never disagree.
    assign merged = (wold & ~wmask) | (d & wmask);

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        ra_ok = ({1'b0, raddr_a} < c_DEPTH) && !((ZERO_REG != 0) && (raddr_a == '0));
        rb_ok = ({1'b0, raddr_b} < c_DEPTH) && !((ZERO_REG != 0) && (raddr_b == '0));

        if (!ra_ok)
            q_a = '0;
        else if ((BYPASS != 0) && wr_acc && (raddr_a == waddr))
            q_a = merged;
        else
            q_a = stored_a;

        if (!rb_ok)
            q_b = '0;
        else if ((BYPASS != 0) && wr_acc && (raddr_b == waddr))
            q_b = merged;
        else
            q_b = stored_b;
    end

    // ------------------------------------------------------------------
    // Storage and dirty flags. The sweep and a write can never coincide
    // because writes are only accepted in IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dirty_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((state_q == S_CLEAR) && (ptr_q == AW'(i))) begin
                    mem_q[i]   <= '0;
                    dirty_q[i] <= 1'b0;
                end else if (wr_acc && (waddr == AW'(i))) begin
                    mem_q[i]   <= merged;
                    dirty_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Clear-sweep FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Clear-sweep FSM: next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                // clr_start is deliberately not looked at here.
                if (ptr_q == c_LAST) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Clear-sweep FSM: outputs
    always_comb begin
        busy = (state_q == S_CLEAR);
    end

    assign wr_drop = wr_drop_q;
    assign dirty   = dirty_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_bank
// Purpose  : Directed scoreboard bench for regfile_bank (WIDTH=32, DEPTH=32,
//            ZERO_REG=1, BYPASS=1). Stimulus queues expected observations for
//            the current cycle; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_bank;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    localparam int SQA = 0;
    localparam int SQB = 1;
    localparam int SDR = 2;
    localparam int SBS = 3;
    localparam int SWD = 4;

    logic          clk = 1'b0;
    logic          res;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  d;
    logic [3:0]    be;
    logic [AW-1:0] raddr_a;
    logic [AW-1:0] raddr_b;
    logic [W-1:0]  q_a;
    logic [W-1:0]  q_b;
    logic          clr_start;
    logic          busy;
    logic          wr_drop;
    logic [D-1:0]  dirty;

    regfile_bank #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clk       (clk),
        .res       (res),
        .we        (we),
        .waddr     (waddr),
        .d         (d),
        .be        (be),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .q_a       (q_a),
        .q_b       (q_b),
        .clr_start (clr_start),
        .busy      (busy),
        .wr_drop   (wr_drop),
        .dirty     (dirty)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    exp_t        m_e;
    logic [31:0] m_act;

    // Monitor: everything queued for this cycle is compared mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            case (m_e.sel)
                SQA:     m_act = q_a;
                SQB:     m_act = q_b;
                SDR:     m_act = dirty;
                SBS:     m_act = {31'b0, busy};
                default: m_act = {31'b0, wr_drop};
            endcase
            checks++;
            if (m_act !== m_e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", m_e.name, m_act, m_e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we        = 1'b0;
        clr_start = 1'b0;
        be        = 4'h0;
        d         = '0;
        waddr     = '0;
    endtask

    task automatic push(input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] v, input logic [3:0] b);
        we    = 1'b1;
        waddr = a;
        d     = v;
        be    = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        res     = 1'b1;
        raddr_a = '0;
        raddr_b = '0;
        idle();
        tick();
        tick();
        res = 1'b0;

        // Reset state
        raddr_a = 5'd5;
        raddr_b = 5'd31;
        push("rst_busy",    SBS, 32'h0);
        push("rst_wr_drop", SWD, 32'h0);
        push("rst_dirty",   SDR, 32'h0);
        push("rst_q_a",     SQA, 32'h0);
        push("rst_q_b",     SQB, 32'h0);
        tick();

        // Full-word write then read back
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        tick();
        idle();
        raddr_a = 5'd5;
        push("wr5_q_a",  SQA, 32'hDEADBEEF);
        push("wr5_dirty", SDR, 32'h0000_0020);
        push("wr5_drop", SWD, 32'h0);
        tick();

        // Partial write with same-cycle bypass
        wr(5'd5, 32'h11223344, 4'h2);
        raddr_a = 5'd5;
        raddr_b = 5'd5;
        push("byp_q_b", SQB, 32'hDEAD33EF);
        push("byp_q_a", SQA, 32'hDEAD33EF);
        tick();
        idle();
        raddr_b = 5'd0;
        push("be2_stored", SQA, 32'hDEAD33EF);
        push("r0_q_b",     SQB, 32'h0);
        tick();

        // Write to zero register is rejected
        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        raddr_a = 5'd0;
        push("z0_q_a_same", SQA, 32'h0);
        push("z0_drop_pre", SWD, 32'h0);
        tick();
        idle();
        push("z0_drop",  SWD, 32'h1);
        push("z0_dirty", SDR, 32'h0000_0020);
        push("z0_q_a",   SQA, 32'h0);
        tick();
        push("z0_drop_clr", SWD, 32'h0);

        // be=0 write marks dirty without changing data
        wr(5'd9, 32'hAAAAAAAA, 4'h0);
        raddr_a = 5'd9;
        push("be0_byp", SQA, 32'h0);
        tick();
        idle();
        push("be0_dirty", SDR, 32'h0000_0220);
        push("be0_q_a",   SQA, 32'h0);
        push("be0_drop",  SWD, 32'h0);
        tick();

        // Full sweep, started together with an accepted write to reg 31
        wr(5'd3, 32'h01020304, 4'hF);
        tick();
        wr(5'd31, 32'hCAFEF00D, 4'hC);
        clr_start = 1'b1;
        raddr_b   = 5'd31;
        push("clrwr_byp",  SQB, 32'hCAFE0000);
        push("clrwr_busy", SBS, 32'h0);
        tick();
        idle();
        raddr_a = 5'd3;
        raddr_b = 5'd31;
        for (int k = 0; k < 32; k++) begin
            push($sformatf("sw1_busy_%0d", k), SBS, 32'h1);
            if (k == 0) begin
                push("sw1_q3_k0",  SQA, 32'h01020304);
                push("sw1_q31_k0", SQB, 32'hCAFE0000);
                push("sw1_dirty0", SDR, 32'h8000_0228);
            end
            if (k == 4) begin
                push("sw1_q3_k4",  SQA, 32'h0);
                push("sw1_dirty4", SDR, 32'h8000_0220);
            end
            if (k == 10) push("sw1_dirty10", SDR, 32'h8000_0000);
            if (k == 31) push("sw1_q31_k31", SQB, 32'hCAFE0000);
            tick();
        end
        push("sw1_busy_end", SBS, 32'h0);
        push("sw1_dirty_end", SDR, 32'h0);
        push("sw1_q3_end",  SQA, 32'h0);
        push("sw1_q31_end", SQB, 32'h0);
        for (int i = 0; i < 16; i++) begin
            raddr_a = AW'(2 * i);
            raddr_b = AW'(2 * i + 1);
            push($sformatf("sw1_zero_a_%0d", 2 * i), SQA, 32'h0);
            push($sformatf("sw1_zero_b_%0d", 2 * i + 1), SQB, 32'h0);
            tick();
        end

        // Sweep with a blocked write and a redundant clr_start
        clr_start = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 32; k++) begin
            idle();
            push($sformatf("sw2_busy_%0d", k), SBS, 32'h1);
            if (k == 5) begin
                wr(5'd7, 32'h12345678, 4'hF);
                raddr_a = 5'd7;
                push("sw2_nobyp", SQA, 32'h0);
            end
            if (k == 6) push("sw2_drop",     SWD, 32'h1);
            if (k == 7) push("sw2_drop_clr", SWD, 32'h0);
            if (k == 12) clr_start = 1'b1;
            tick();
        end
        idle();
        raddr_a = 5'd7;
        push("sw2_busy_end", SBS, 32'h0);
        push("sw2_q7",       SQA, 32'h0);
        push("sw2_dirty",    SDR, 32'h0);
        tick();
        push("sw2_no_restart", SBS, 32'h0);

        // Reset in the middle of a sweep
        wr(5'd2, 32'h00000055, 4'hF);
        tick();
        wr(5'd20, 32'h00000077, 4'hF);
        clr_start = 1'b1;
        tick();
        idle();
        raddr_a = 5'd20;
        for (int k = 0; k <= 10; k++) begin
            push($sformatf("sw3_busy_%0d", k), SBS, 32'h1);
            if (k == 10) begin
                push("sw3_q20_pre", SQA, 32'h00000077);
                res = 1'b1;
            end
            tick();
        end
        res     = 1'b0;
        raddr_b = 5'd2;
        push("sw3_busy_rst",  SBS, 32'h0);
        push("sw3_dirty_rst", SDR, 32'h0);
        push("sw3_q20_rst",   SQA, 32'h0);
        push("sw3_q2_rst",    SQB, 32'h0);
        push("sw3_drop_rst",  SWD, 32'h0);
        tick();
        push("sw3_no_resume", SBS, 32'h0);
        wr(5'd2, 32'h00000099, 4'hF);
        tick();
        idle();
        push("post_dirty", SDR, 32'h0000_0004);
        push("post_q2",    SQB, 32'h00000099);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
